// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes,
// function codes and PC source selects.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    function automatic logic is_shift(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA) ||
               (fn == FN_SLLV) || (fn == FN_SRLV) || (fn == FN_SRAV);
    endfunction

endpackage

// File: rtl/controller_decode.sv
// Combinational level decode of the latched instruction; no state, no strobes.
module controller_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       i_format,
    output logic       sftmd,
    output logic       jr,
    output logic       jmp,
    output logic       jal,
    output logic       branch,
    output logic       nbranch,
    output logic [1:0] alu_op,
    output logic       lw,
    output logic       sw,
    output logic       reg_write_en
);

    logic r_type;
    logic i_type;

    always_comb begin
        r_type   = (op == OP_R);
        jmp      = (op == OP_J);
        jal      = (op == OP_JAL);
        branch   = (op == OP_BEQ);
        nbranch  = (op == OP_BNE);
        lw       = (op == OP_LW);
        sw       = (op == OP_SW);
        jr       = r_type && (funct == FN_JR);
        sftmd    = r_type && is_shift(funct);
        // Anything that is neither R-type nor a jump is treated as I-type.
        i_type   = !r_type && !jmp && !jal;
        alu_src  = i_type && !branch && !nbranch;
        i_format = i_type && !branch && !nbranch && !lw && !sw;
        reg_dst  = r_type;
        alu_op   = {r_type || i_format, branch || nbranch};
        reg_write_en = (r_type || lw || jal || i_format) && !jr;
    end

endmodule

// File: rtl/multicycle_controller_io.sv
// Multi-cycle FSM controller: sequences FETCH/DECODE/EXEC/MEM/WB and steers
// loads/stores to memory (fixed latency) or IO (ready handshake with timeout).
module multicycle_controller_io
    import ctrl_pkg::*;
#(
    parameter int ADDR_HIGH_W = 22,
    parameter logic [ADDR_HIGH_W-1:0] IO_MATCH = {ADDR_HIGH_W{1'b1}},
    parameter int MEM_LAT    = 1,
    parameter int IO_TIMEOUT = 15
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [5:0]             Opcode,
    input  logic [5:0]             Function_opcode,
    input  logic [ADDR_HIGH_W-1:0] Alu_resultHigh,
    input  logic                   io_ready,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic [1:0]             pc_src,
    output logic                   RegDST,
    output logic                   ALUSrc,
    output logic                   I_format,
    output logic                   Sftmd,
    output logic                   Jr,
    output logic                   Jmp,
    output logic                   Jal,
    output logic                   Branch,
    output logic                   nBranch,
    output logic [1:0]             ALUOp,
    output logic                   RegWrite,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IORead,
    output logic                   IOWrite,
    output logic                   MemorIOtoReg,
    output logic                   io_err,
    output logic [2:0]             state
);

    localparam int CNT_MAX = (MEM_LAT > IO_TIMEOUT) ? MEM_LAT : IO_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] IO_LAST  = CNT_W'(IO_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [5:0]       op_q, funct_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_io_q, io_err_q;
    logic             io_timeout;
    logic             lw, sw, reg_write_en;

    controller_decode u_decode (
        .op           (op_q),
        .funct        (funct_q),
        .reg_dst      (RegDST),
        .alu_src      (ALUSrc),
        .i_format     (I_format),
        .sftmd        (Sftmd),
        .jr           (Jr),
        .jmp          (Jmp),
        .jal          (Jal),
        .branch       (Branch),
        .nbranch      (nBranch),
        .alu_op       (ALUOp),
        .lw           (lw),
        .sw           (sw),
        .reg_write_en (reg_write_en)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_FETCH;
            op_q     <= '0;
            funct_q  <= '0;
            cnt_q    <= '0;
            is_io_q  <= 1'b0;
            io_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q    <= Opcode;
                funct_q <= Function_opcode;
            end
            if (state_q == ST_EXEC && (lw || sw)) begin
                cnt_q   <= '0;
                is_io_q <= (Alu_resultHigh == IO_MATCH);
            end else if (state_q == ST_MEM && cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (io_timeout) io_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_d       = ST_FETCH;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_SEQ;
        RegWrite      = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IORead        = 1'b0;
        IOWrite       = 1'b0;
        MemorIOtoReg  = 1'b0;
        io_timeout    = 1'b0;
        // Strobes are forced low while reset is held, not just after the edge.
        if (reset_n) begin
            case (state_q)
                ST_FETCH: begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SEQ;
                    state_d  = ST_DECODE;
                end
                ST_DECODE: begin
                    // Opcode is being latched this cycle, so branch on the live value.
                    if (Opcode == OP_J) begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                        state_d  = ST_FETCH;
                    end else if (Opcode == OP_JAL) begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                        state_d  = ST_WB;
                    end else begin
                        state_d  = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (Branch || nBranch) begin
                        pc_write_cond = 1'b1;
                        pc_src        = PC_BRANCH;
                        state_d       = ST_FETCH;
                    end else if (Jr) begin
                        pc_write = 1'b1;
                        pc_src   = PC_REG;
                        state_d  = ST_FETCH;
                    end else if (lw || sw) begin
                        state_d  = ST_MEM;
                    end else begin
                        state_d  = ST_WB;
                    end
                end
                ST_MEM: begin
                    if (!is_io_q) begin
                        MemRead  = lw;
                        MemWrite = sw;
                        if (cnt_q >= MEM_LAST) state_d = lw ? ST_WB : ST_FETCH;
                        else                   state_d = ST_MEM;
                    end else begin
                        IORead  = lw;
                        IOWrite = sw;
                        if (io_ready) begin
                            state_d = lw ? ST_WB : ST_FETCH;
                        end else if (cnt_q >= IO_LAST) begin
                            io_timeout = 1'b1;
                            state_d    = ST_FETCH;
                        end else begin
                            state_d = ST_MEM;
                        end
                    end
                end
                ST_WB: begin
                    RegWrite     = reg_write_en;
                    MemorIOtoReg = lw;
                    state_d      = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    assign io_err = io_err_q;
    assign state  = state_q;

endmodule

// File: tb/tb_multicycle_controller_io.sv
// Directed bench for multicycle_controller_io with MEM_LAT=2, IO_TIMEOUT=15.
module tb_multicycle_controller_io;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  Opcode = '0;
    logic [5:0]  Function_opcode = '0;
    logic [21:0] Alu_resultHigh = '0;
    logic        io_ready = 1'b0;
    logic        ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_src, ALUOp;
    logic        RegDST, ALUSrc, I_format, Sftmd, Jr, Jmp, Jal, Branch, nBranch;
    logic        RegWrite, MemRead, MemWrite, IORead, IOWrite, MemorIOtoReg, io_err;
    logic [2:0]  state;

    multicycle_controller_io #(
        .ADDR_HIGH_W (22),
        .IO_MATCH    (22'h3FFFFF),
        .MEM_LAT     (2),
        .IO_TIMEOUT  (15)
    ) dut (
        .clock (clock), .reset_n (reset_n), .Opcode (Opcode),
        .Function_opcode (Function_opcode), .Alu_resultHigh (Alu_resultHigh),
        .io_ready (io_ready), .ir_write (ir_write), .pc_write (pc_write),
        .pc_write_cond (pc_write_cond), .pc_src (pc_src), .RegDST (RegDST),
        .ALUSrc (ALUSrc), .I_format (I_format), .Sftmd (Sftmd), .Jr (Jr),
        .Jmp (Jmp), .Jal (Jal), .Branch (Branch), .nBranch (nBranch),
        .ALUOp (ALUOp), .RegWrite (RegWrite), .MemRead (MemRead),
        .MemWrite (MemWrite), .IORead (IORead), .IOWrite (IOWrite),
        .MemorIOtoReg (MemorIOtoReg), .io_err (io_err), .state (state)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];
    int cnt_rw, cnt_mr, cnt_mw, cnt_ior, cnt_iow, cnt_m2r;
    logic       log_pcw[32], log_pcc[32], log_rw[32], log_jal[32], log_rdst[32];
    logic [1:0] log_pcs[32], log_aluop[32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic [2:0] s, input int n);
        repeat (n) exp_q.push_back(s);
    endtask

    // Drives one instruction, checks the state sequence queued in exp_q and
    // logs per-cycle strobes; io_ready is pulsed in cycle rdy_idx.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic [21:0] hi, input int rdy_idx);
        int i;
        Opcode = op; Function_opcode = fn; Alu_resultHigh = hi;
        cnt_rw = 0; cnt_mr = 0; cnt_mw = 0; cnt_ior = 0; cnt_iow = 0; cnt_m2r = 0;
        i = 0;
        while (exp_q.size() > 0 && i < 32) begin
            io_ready = (i == rdy_idx);
            #1;
            check($sformatf("%s/state[%0d]", tag, i), 32'(state), 32'(exp_q.pop_front()));
            log_pcw[i] = pc_write; log_pcc[i] = pc_write_cond; log_pcs[i] = pc_src;
            log_rw[i] = RegWrite; log_jal[i] = Jal; log_rdst[i] = RegDST; log_aluop[i] = ALUOp;
            cnt_rw += int'(RegWrite); cnt_mr += int'(MemRead); cnt_mw += int'(MemWrite);
            cnt_ior += int'(IORead); cnt_iow += int'(IOWrite); cnt_m2r += int'(MemorIOtoReg);
            @(posedge clock); #1;
            i++;
        end
        io_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst/state", 32'(state), 0);
        check("rst/ir_write", 32'(ir_write), 0);
        check("rst/pc_write", 32'(pc_write), 0);
        check("rst/io_err", 32'(io_err), 0);
        check("rst/RegDST", 32'(RegDST), 1);
        check("rst/ALUOp", 32'(ALUOp), 2);
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        check("fetch/ir_write", 32'(ir_write), 1);
        check("fetch/pc_write", 32'(pc_write), 1);

        // add: FETCH, DECODE, EXEC, WB
        exp_push(0, 1); exp_push(1, 1); exp_push(2, 1); exp_push(4, 1);
        run_instr("add", 6'h00, 6'h20, 22'h0, -1);
        check("add/rw_count", 32'(cnt_rw), 1);
        check("add/rw_wb", 32'(log_rw[3]), 1);
        check("add/RegDST", 32'(log_rdst[2]), 1);
        check("add/ALUOp", 32'(log_aluop[2]), 2);
        check("add/end_state", 32'(state), 0);

        // lw to memory, two MEM cycles
        exp_push(0, 1); exp_push(1, 1); exp_push(2, 1); exp_push(3, 2); exp_push(4, 1);
        run_instr("lw_mem", 6'h23, 6'h00, 22'h0, -1);
        check("lw_mem/MemRead", 32'(cnt_mr), 2);
        check("lw_mem/IORead", 32'(cnt_ior), 0);
        check("lw_mem/MemorIOtoReg", 32'(cnt_m2r), 1);
        check("lw_mem/rw_wb", 32'(log_rw[5]), 1);
        check("lw_mem/rw_count", 32'(cnt_rw), 1);

        // sw to IO, ready in the third MEM cycle
        exp_push(0, 1); exp_push(1, 1); exp_push(2, 1); exp_push(3, 3);
        run_instr("sw_io", 6'h2B, 6'h00, 22'h3FFFFF, 5);
        check("sw_io/IOWrite", 32'(cnt_iow), 3);
        check("sw_io/MemWrite", 32'(cnt_mw), 0);
        check("sw_io/rw_count", 32'(cnt_rw), 0);
        check("sw_io/end_state", 32'(state), 0);

        // lw to IO that never becomes ready
        check("lw_to/io_err_before", 32'(io_err), 0);
        exp_push(0, 1); exp_push(1, 1); exp_push(2, 1); exp_push(3, 15);
        run_instr("lw_to", 6'h23, 6'h00, 22'h3FFFFF, -1);
        check("lw_to/IORead", 32'(cnt_ior), 15);
        check("lw_to/rw_count", 32'(cnt_rw), 0);
        check("lw_to/io_err", 32'(io_err), 1);
        check("lw_to/end_state", 32'(state), 0);

        // jal: FETCH, DECODE, WB
        exp_push(0, 1); exp_push(1, 1); exp_push(4, 1);
        run_instr("jal", 6'h03, 6'h00, 22'h0, -1);
        check("jal/pc_write", 32'(log_pcw[1]), 1);
        check("jal/pc_src", 32'(log_pcs[1]), 2);
        check("jal/rw_wb", 32'(log_rw[2]), 1);
        check("jal/Jal_wb", 32'(log_jal[2]), 1);
        check("jal/io_err_sticky", 32'(io_err), 1);

        // jr: FETCH, DECODE, EXEC
        exp_push(0, 1); exp_push(1, 1); exp_push(2, 1);
        run_instr("jr", 6'h00, 6'h08, 22'h0, -1);
        check("jr/pc_write", 32'(log_pcw[2]), 1);
        check("jr/pc_src", 32'(log_pcs[2]), 3);
        check("jr/rw_count", 32'(cnt_rw), 0);

        // beq: FETCH, DECODE, EXEC
        exp_push(0, 1); exp_push(1, 1); exp_push(2, 1);
        run_instr("beq", 6'h04, 6'h00, 22'h0, -1);
        check("beq/pc_write_cond", 32'(log_pcc[2]), 1);
        check("beq/pc_src", 32'(log_pcs[2]), 1);

        // j: FETCH, DECODE
        exp_push(0, 1); exp_push(1, 1);
        run_instr("j", 6'h02, 6'h00, 22'h0, -1);
        check("j/pc_src", 32'(log_pcs[1]), 2);
        check("j/end_state", 32'(state), 0);

        // reset in the middle of an IO write
        exp_push(0, 1); exp_push(1, 1); exp_push(2, 1); exp_push(3, 1);
        run_instr("sw_rst", 6'h2B, 6'h00, 22'h3FFFFF, -1);
        check("sw_rst/in_mem", 32'(state), 3);
        check("sw_rst/IOWrite_pre", 32'(IOWrite), 1);
        reset_n = 1'b0;
        #1;
        check("sw_rst/IOWrite_async", 32'(IOWrite), 0);
        check("sw_rst/state_async", 32'(state), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        check("sw_rst/io_err_cleared", 32'(io_err), 0);
        check("sw_rst/state_after", 32'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller_io.md
Name: multicycle_controller_io

Overview:
Multi-cycle successor to the single-cycle MIPS control unit; it sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with an FSM. Memory/IO steering is parametrised: IO window match value, memory latency, and IO ready-handshake with timeout. Sits between the IFetch IR and the decoder, ALU, data-memory and MemOrIO units, and drives all control strobes per state.

Parameters:
ADDR_HIGH_W, 22, width of Alu_resultHigh (ALU result bits above the word offset)
IO_MATCH, {ADDR_HIGH_W{1'b1}}, Alu_resultHigh value selecting the IO space
MEM_LAT, 1, cycles MemRead/MemWrite are held in MEM (>=1)
IO_TIMEOUT, 15, max MEM cycles waiting for io_ready (>=1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
Opcode  in  6  IR[31:26], valid from DECODE onward
Function_opcode  in  6  IR[5:0]
Alu_resultHigh  in  ADDR_HIGH_W  ALU result high bits, valid in EXEC
io_ready  in  1  IO device completes access
ir_write  out  1  load IR (FETCH)
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load qualified by datapath branch test
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=register (jr)
RegDST, ALUSrc, I_format, Sftmd, Jr, Jmp, Jal, Branch, nBranch  out  1 each  level decode of latched instruction
ALUOp  out  2  {R_type|I_format, beq|bne}
RegWrite  out  1  register file write strobe (WB only)
MemRead, MemWrite, IORead, IOWrite  out  1 each  access strobes (MEM only)
MemorIOtoReg  out  1  WB data from memory/IO
io_err  out  1  sticky IO timeout flag
state  out  3  current FSM state (debug)

Behaviour:
- Reset (async, reset_n=0): state=FETCH; latched opcode/funct=0; counters=0; is_io=0; io_err=0; every strobe 0. Level decode then reflects opcode 0 (RegDST=1, ALUOp=2'b10), harmless because no strobe fires. Reset mid-MEM drops strobes in the same instant.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 return to FETCH.
- FETCH: ir_write=1, pc_write=1, pc_src=0. Next: DECODE.
- DECODE: latch Opcode and Function_opcode. j: pc_write=1, pc_src=2, next FETCH. jal: pc_write=1, pc_src=2, next WB. Otherwise next EXEC.
- EXEC: beq/bne: pc_write_cond=1, pc_src=1, next FETCH. jr: pc_write=1, pc_src=3, next FETCH. lw/sw: register is_io=(Alu_resultHigh==IO_MATCH), clear counter, next MEM. Anything else (R/I-format; unknown opcodes count as I-format): next WB.
- MEM, memory (is_io=0): MemRead (lw) or MemWrite (sw) held exactly MEM_LAT cycles. Then lw goes to WB and sw goes to FETCH.
- MEM, IO (is_io=1): IORead/IOWrite held until io_ready=1 is sampled, inclusive of that cycle. Then lw goes to WB and sw goes to FETCH.
- IO timeout: if io_ready is still 0 after IO_TIMEOUT cycles, set io_err=1, drop the strobe, go to FETCH. WB is skipped, so there is no register write.
- WB: RegWrite=1 for one cycle. MemorIOtoReg=1 when the instruction is lw. Jal writes $31; the datapath selects this via Jal. Next FETCH.
- Level decode, from latched opcode/funct:
  - Jr = (op==0 && funct==8).
  - Sftmd = R-type && funct in {0,2,3,4,6,7}.
  - ALUSrc = I-type && !beq && !bne.
  - I_format = I-type excluding beq/bne/lw/sw.
  - RegWrite enable term = (R|lw|jal|I_format) && !Jr, gated by WB.
- Cycle counts per instruction:
  - R/I-format: 4.
  - j: 2. jal: 3. beq/bne/jr: 3.
  - sw memory: 3+MEM_LAT. lw memory: 4+MEM_LAT.
  - IO: 3 or 4 plus the wait cycles.
- Counter width: clog2(max(MEM_LAT, IO_TIMEOUT)+1). It saturates and does not wrap.

Decomposition:
- Package ctrl_pkg holds:
  - state localparams.
  - opcode constants: R=0, J=2, JAL=3, BEQ=4, BNE=5, LW=0x23, SW=0x2B.
  - funct constants: JR=8 and the shift set.
  - pc_src encodings.
- Sub-module controller_decode: purely combinational, opcode/funct to level signals. The FSM wrapper owns state, counter, is_io, io_err and strobe gating.

Test Plan:
- add (op 0, funct 0x20) after reset: ir_write in cycle 0, EXEC in cycle 2, RegWrite=1 only in cycle 3, RegDST=1, ALUOp=2'b10, then back to FETCH.
- lw (0x23) with MEM_LAT=2 and Alu_resultHigh=0: MemRead=1 for exactly 2 cycles, IORead=0, then WB with MemorIOtoReg=1 and RegWrite=1; total 6 cycles.
- sw (0x2B) with Alu_resultHigh=22'h3FFFFF and io_ready raised in the 3rd MEM cycle: IOWrite=1 for 3 cycles, MemWrite=0, no WB, then FETCH.
- lw to IO with io_ready stuck at 0 and IO_TIMEOUT=15: IORead for 15 cycles, then io_err=1 (sticky), RegWrite never asserted, next state FETCH.
- jal (0x03): pc_write=1 with pc_src=2 in DECODE, RegWrite=1 with Jal=1 in WB; 3 cycles. jr: pc_src=3 in EXEC.
- reset_n pulsed low during MEM of an IO write: IOWrite drops asynchronously, state=FETCH, io_err=0 after release.
